// File: rtl/pkfb_push_arbiter.sv
// Four-requester round-robin arbiter feeding the ASSP packet FIFO push port.
// Whole packets are granted; length overrun and FIFO overflow divert the rest of the packet to a drain.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no owner, arbitrating among pending requesters
//   ST_XFER  | owner's words accepted and pushed one cycle later
//   ST_DRAIN | owner's words accepted and discarded until Req_Last
module pkfb_push_arbiter #(
   parameter int MAX_WORDS = 256
) (
   input  logic         Sys_PKfb_Clk,
   input  logic         Sys_PKfb_Rst_n,
   input  logic [3:0]   Req_Valid,
   input  logic [127:0] Req_Data,
   input  logic [3:0]   Req_Last,
   output logic [3:0]   Req_Ready,
   output logic [31:0]  FB_PKfbData,
   output logic [3:0]   FB_PKfbPush,
   output logic         FB_PKfbSOF,
   output logic         FB_PKfbEOF,
   input  logic         FB_PKfbOverflow,
   input  logic         Sts_Clr,
   output logic [3:0]   Ovf_Sticky,
   output logic [3:0]   Len_Err,
   output logic [3:0]   Grant
);

   localparam int CW = $clog2(MAX_WORDS + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    grant_q, grant_d;
   logic [1:0]    rr_q, rr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   data_q, data_d;
   logic [3:0]    push_q, push_d;
   logic          sof_q, sof_d;
   logic          eof_q, eof_d;
   logic [3:0]    ovf_q, ovf_d;
   logic [3:0]    len_q, len_d;

   logic [1:0]    owner;
   logic [1:0]    cand;
   logic [1:0]    pick_idx;
   logic          pick_found;
   logic          accept;
   logic          sel_last;
   logic [31:0]   sel_data;
   logic          at_max;
   logic [3:0]    ovf_set;
   logic [3:0]    len_set;

   always_comb begin
      owner = '0;
      for (int i = 0; i < 4; i++) begin
         if (grant_q[i]) owner = 2'(i);
      end
   end

   // rr_q holds the first requester to consider, i.e. one past the last owner
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = rr_q;
      cand       = '0;
      for (int k = 0; k < 4; k++) begin
         cand = rr_q + 2'(k);
         if (!pick_found && Req_Valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign accept   = |(Req_Valid & grant_q);
   assign sel_last = Req_Last[owner];
   assign sel_data = Req_Data[{owner, 5'd0} +: 32];
   assign at_max   = (cnt_q == CW'(MAX_WORDS - 1));

   assign Req_Ready = (state_q == ST_IDLE) ? 4'b0000 : grant_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      push_d  = 4'b0000;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      ovf_set = 4'b0000;
      len_set = 4'b0000;

      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_d = 4'b0001 << pick_idx;
               cnt_d   = '0;
               state_d = ST_XFER;
            end
         end

         ST_XFER: begin
            if (FB_PKfbOverflow) begin
               // a word accepted alongside the overflow is dropped, not pushed
               ovf_set = grant_q;
               if (accept && sel_last) begin
                  state_d = ST_IDLE;
                  grant_d = 4'b0000;
                  rr_d    = owner + 2'd1;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else if (accept) begin
               cnt_d  = cnt_q + 1'b1;
               push_d = grant_q;
               data_d = sel_data;
               sof_d  = (cnt_q == '0);
               eof_d  = sel_last | at_max;
               if (sel_last) begin
                  state_d = ST_IDLE;
                  grant_d = 4'b0000;
                  rr_d    = owner + 2'd1;
               end else if (at_max) begin
                  len_set = grant_q;
                  state_d = ST_DRAIN;
               end
            end
         end

         ST_DRAIN: begin
            if (accept && sel_last) begin
               state_d = ST_IDLE;
               grant_d = 4'b0000;
               rr_d    = owner + 2'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
         end
      endcase

      ovf_d = (Sts_Clr ? 4'b0000 : ovf_q) | ovf_set;
      len_d = (Sts_Clr ? 4'b0000 : len_q) | len_set;
   end

   always_ff @(posedge Sys_PKfb_Clk or negedge Sys_PKfb_Rst_n) begin
      if (!Sys_PKfb_Rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= 4'b0000;
         rr_q    <= 2'd0;
         cnt_q   <= '0;
         data_q  <= 32'd0;
         push_q  <= 4'b0000;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         ovf_q   <= 4'b0000;
         len_q   <= 4'b0000;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         push_q  <= push_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
         ovf_q   <= ovf_d;
         len_q   <= len_d;
      end
   end

   assign Grant       = grant_q;
   assign FB_PKfbData = data_q;
   assign FB_PKfbPush = push_q;
   assign FB_PKfbSOF  = sof_q;
   assign FB_PKfbEOF  = eof_q;
   assign Ovf_Sticky  = ovf_q;
   assign Len_Err     = len_q;

endmodule

// File: tb/tb_pkfb_push_arbiter.sv
// Bench for pkfb_push_arbiter: directed packet scenarios plus randomized traffic,
// every cycle compared against a packet-level reference model.
module tb_pkfb_push_arbiter;

   localparam int MAXW = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   Req_Valid;
   logic [127:0] Req_Data;
   logic [3:0]   Req_Last;
   logic [3:0]   Req_Ready;
   logic [31:0]  FB_PKfbData;
   logic [3:0]   FB_PKfbPush;
   logic         FB_PKfbSOF;
   logic         FB_PKfbEOF;
   logic         FB_PKfbOverflow;
   logic         Sts_Clr;
   logic [3:0]   Ovf_Sticky;
   logic [3:0]   Len_Err;
   logic [3:0]   Grant;

   always #5 clk = ~clk;

   pkfb_push_arbiter #(.MAX_WORDS(MAXW)) dut (
      .Sys_PKfb_Clk    (clk),
      .Sys_PKfb_Rst_n  (rst_n),
      .Req_Valid       (Req_Valid),
      .Req_Data        (Req_Data),
      .Req_Last        (Req_Last),
      .Req_Ready       (Req_Ready),
      .FB_PKfbData     (FB_PKfbData),
      .FB_PKfbPush     (FB_PKfbPush),
      .FB_PKfbSOF      (FB_PKfbSOF),
      .FB_PKfbEOF      (FB_PKfbEOF),
      .FB_PKfbOverflow (FB_PKfbOverflow),
      .Sts_Clr         (Sts_Clr),
      .Ovf_Sticky      (Ovf_Sticky),
      .Len_Err         (Len_Err),
      .Grant           (Grant)
   );

   typedef struct {
      logic [31:0] d;
      logic        l;
   } word_t;

   typedef struct {
      logic [3:0]  ch;
      logic [31:0] d;
      logic        s;
      logic        e;
      int          cyc;
   } push_t;

   word_t rq[4][$];
   push_t plog[$];
   logic [3:0] acc_pend = 4'b0000;
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference model: tracks the packet owner and how many of its words went out
   logic [3:0]  exp_grant = 4'b0000;
   logic [3:0]  exp_push = 4'b0000;
   logic [31:0] exp_data = 32'd0;
   logic        exp_sof = 1'b0;
   logic        exp_eof = 1'b0;
   logic [3:0]  exp_ovf = 4'b0000;
   logic [3:0]  exp_len = 4'b0000;
   int          own = -1;
   int          nwords = 0;
   int          nstart = 0;
   bit          dropping = 0;
   bit          m_acc, m_last, m_done;
   logic [31:0] m_word;
   logic [3:0]  m_ovf_set, m_len_set;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_grant = 0; exp_push = 0; exp_data = 0; exp_sof = 0; exp_eof = 0;
         exp_ovf = 0; exp_len = 0; own = -1; nwords = 0; nstart = 0; dropping = 0;
      end else begin
         exp_push = 0; exp_sof = 0; exp_eof = 0;
         m_ovf_set = 0; m_len_set = 0;
         if (own < 0) begin
            for (int k = 0; k < 4; k++) begin
               if (own < 0 && Req_Valid[(nstart + k) % 4]) begin
                  own = (nstart + k) % 4;
                  nwords = 0;
                  dropping = 0;
               end
            end
         end else begin
            m_acc  = Req_Valid[own];
            m_last = Req_Last[own];
            m_word = Req_Data[own*32 +: 32];
            m_done = 0;
            if (!dropping && FB_PKfbOverflow) begin
               m_ovf_set[own] = 1'b1;
               if (m_acc && m_last) m_done = 1;
               else dropping = 1;
            end else if (!dropping) begin
               if (m_acc) begin
                  nwords++;
                  exp_push[own] = 1'b1;
                  exp_data = m_word;
                  exp_sof = (nwords == 1);
                  exp_eof = m_last || (nwords == MAXW);
                  if (m_last) m_done = 1;
                  else if (nwords == MAXW) begin
                     m_len_set[own] = 1'b1;
                     dropping = 1;
                  end
               end
            end else if (m_acc && m_last) begin
               m_done = 1;
            end
            if (m_done) begin
               nstart = (own + 1) % 4;
               own = -1;
            end
         end
         exp_ovf = (Sts_Clr ? 4'b0000 : exp_ovf) | m_ovf_set;
         exp_len = (Sts_Clr ? 4'b0000 : exp_len) | m_len_set;
         exp_grant = (own < 0) ? 4'b0000 : (4'b0001 << own);
      end
   end

   task automatic sample();
      @(negedge clk);
      cyc++;
      chk("grant",  32'(Grant),       32'(exp_grant));
      chk("ready",  32'(Req_Ready),   32'(exp_grant));
      chk("push",   32'(FB_PKfbPush), 32'(exp_push));
      chk("data",   FB_PKfbData,      exp_data);
      chk("sof",    32'(FB_PKfbSOF),  32'(exp_sof));
      chk("eof",    32'(FB_PKfbEOF),  32'(exp_eof));
      chk("ovf_st", 32'(Ovf_Sticky),  32'(exp_ovf));
      chk("len_err",32'(Len_Err),     32'(exp_len));
      if (FB_PKfbPush != 4'b0000)
         plog.push_back('{ch: FB_PKfbPush, d: FB_PKfbData, s: FB_PKfbSOF, e: FB_PKfbEOF, cyc: cyc});
      for (int i = 0; i < 4; i++)
         if (acc_pend[i] && rq[i].size() > 0) void'(rq[i].pop_front());
   endtask

   task automatic drive(input logic ovf, input logic clr, input int gate_pct);
      for (int i = 0; i < 4; i++) begin
         Req_Valid[i] = (rq[i].size() > 0) && ($urandom_range(99) < gate_pct);
         if (rq[i].size() > 0) begin
            Req_Data[i*32 +: 32] = rq[i][0].d;
            Req_Last[i] = rq[i][0].l;
         end else begin
            Req_Data[i*32 +: 32] = $urandom();
            Req_Last[i] = 1'($urandom_range(1));
         end
      end
      FB_PKfbOverflow = ovf;
      Sts_Clr = clr;
      acc_pend = Req_Valid & Req_Ready;
   endtask

   task automatic send(input int ch, input int n, input logic [31:0] base);
      for (int j = 0; j < n; j++) rq[ch].push_back('{d: base + 32'(j), l: (j == n - 1)});
   endtask

   function automatic bit all_empty();
      return rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0;
   endfunction

   task automatic run_idle(input int gate_pct, input int max_cyc);
      int n;
      n = 0;
      while (n < max_cyc && !(all_empty() && acc_pend == 0 && Grant == 0)) begin
         sample();
         drive(1'b0, 1'b0, gate_pct);
         n++;
      end
      chk("idle_timeout", 32'(n < max_cyc), 32'd1);
      sample();
      drive(1'b0, 1'b0, gate_pct);
   endtask

   logic [3:0] rr_order [5];
   bit fired;
   int n_wait;

   initial begin
      Req_Valid = 0; Req_Data = 0; Req_Last = 0; FB_PKfbOverflow = 0; Sts_Clr = 0;
      repeat (3) begin
         sample();
         drive(1'b0, 1'b0, 100);
      end
      chk("rst_grant", 32'(Grant), 32'd0);
      chk("rst_push",  32'(FB_PKfbPush), 32'd0);
      chk("rst_ovf",   32'(Ovf_Sticky), 32'd0);
      rst_n = 1'b1;

      // round robin over one-word packets with all requesters pending
      plog.delete();
      send(0, 1, 32'hB0); send(1, 1, 32'hB1); send(2, 1, 32'hB2); send(3, 1, 32'hB3); send(0, 1, 32'hB4);
      run_idle(100, 60);
      rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
      rr_order[3] = 4'b1000; rr_order[4] = 4'b0001;
      chk("rr_count", 32'(plog.size()), 32'd5);
      for (int k = 0; k < 5 && k < plog.size(); k++) begin
         chk("rr_ch", 32'(plog[k].ch), 32'(rr_order[k]));
         chk("rr_sof_eof", {30'd0, plog[k].s, plog[k].e}, 32'd3);
         if (k > 0) chk("rr_gap", 32'(plog[k].cyc - plog[k-1].cyc), 32'd2);
      end

      // three-word packet from requester 0
      plog.delete();
      send(0, 3, 32'hA0);
      run_idle(100, 40);
      chk("p3_count", 32'(plog.size()), 32'd3);
      for (int k = 0; k < 3 && k < plog.size(); k++) begin
         chk("p3_ch", 32'(plog[k].ch), 32'd1);
         chk("p3_data", plog[k].d, 32'hA0 + 32'(k));
         chk("p3_sof", 32'(plog[k].s), 32'(k == 0));
         chk("p3_eof", 32'(plog[k].e), 32'(k == 2));
         if (k > 0) chk("p3_gap", 32'(plog[k].cyc - plog[k-1].cyc), 32'd1);
      end

      // over-length packet from requester 2
      plog.delete();
      send(2, 6, 32'hC0);
      run_idle(100, 40);
      chk("len_count", 32'(plog.size()), 32'd4);
      for (int k = 0; k < 4 && k < plog.size(); k++) begin
         chk("len_ch", 32'(plog[k].ch), 32'd4);
         chk("len_data", plog[k].d, 32'hC0 + 32'(k));
         chk("len_eof", 32'(plog[k].e), 32'(k == 3));
      end
      chk("len_err_bit", 32'(Len_Err), 32'b0100);
      chk("len_idle", 32'(Grant), 32'd0);

      // FIFO overflow after the second push of a five-word packet
      plog.delete();
      send(1, 5, 32'hD0);
      fired = 0;
      n_wait = 0;
      while (n_wait < 40 && !(fired && all_empty() && acc_pend == 0 && Grant == 0)) begin
         sample();
         drive(!fired && plog.size() == 2, 1'b0, 100);
         if (plog.size() == 2) fired = 1;
         n_wait++;
      end
      chk("ovf_timeout", 32'(n_wait < 40), 32'd1);
      sample(); drive(1'b0, 1'b0, 100);
      chk("ovf_count", 32'(plog.size()), 32'd2);
      chk("ovf_sticky", 32'(Ovf_Sticky), 32'b0010);
      chk("ovf_idle", 32'(Grant), 32'd0);

      // clear and new overflow in the same cycle: set wins
      plog.delete();
      send(0, 4, 32'hE0);
      fired = 0;
      n_wait = 0;
      while (n_wait < 40 && !(fired && all_empty() && acc_pend == 0 && Grant == 0)) begin
         sample();
         drive(!fired && plog.size() == 1, !fired && plog.size() == 1, 100);
         if (plog.size() == 1) fired = 1;
         n_wait++;
      end
      chk("clr_timeout", 32'(n_wait < 40), 32'd1);
      chk("clr_same", 32'(Ovf_Sticky), 32'b0001);
      chk("clr_len", 32'(Len_Err), 32'd0);
      sample(); drive(1'b0, 1'b1, 100);
      sample(); drive(1'b0, 1'b0, 100);
      chk("clr_alone", 32'(Ovf_Sticky), 32'd0);

      // reset in the middle of a packet
      plog.delete();
      send(0, 5, 32'hF0);
      n_wait = 0;
      while (n_wait < 20 && plog.size() < 2) begin
         sample();
         drive(1'b0, 1'b0, 100);
         n_wait++;
      end
      chk("mid_timeout", 32'(n_wait < 20), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_grant", 32'(Grant), 32'd0);
      chk("arst_ready", 32'(Req_Ready), 32'd0);
      chk("arst_push", 32'(FB_PKfbPush), 32'd0);
      chk("arst_sof_eof", {30'd0, FB_PKfbSOF, FB_PKfbEOF}, 32'd0);
      chk("arst_data", FB_PKfbData, 32'd0);
      for (int i = 0; i < 4; i++) rq[i].delete();
      acc_pend = 0;
      Req_Valid = 0;
      repeat (2) begin
         sample();
         drive(1'b0, 1'b0, 100);
      end
      rst_n = 1'b1;
      plog.delete();
      send(3, 2, 32'h90);
      n_wait = 0;
      while (n_wait < 4 && Grant == 0) begin
         sample();
         drive(1'b0, 1'b0, 100);
         n_wait++;
      end
      chk("post_rst_grant", 32'(Grant), 32'b1000);
      run_idle(100, 30);
      chk("post_rst_count", 32'(plog.size()), 32'd2);
      if (plog.size() > 0) begin
         chk("post_rst_ch", 32'(plog[0].ch), 32'b1000);
         chk("post_rst_sof", 32'(plog[0].s), 32'd1);
         chk("post_rst_data", plog[0].d, 32'h90);
      end

      // randomized traffic with stalls, overflows and clears
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(7) == 0) begin
            int ch;
            ch = $urandom_range(3);
            if (rq[ch].size() < 8) send(ch, $urandom_range(7, 1), $urandom());
         end
         sample();
         drive($urandom_range(29) == 0, $urandom_range(39) == 0, 70);
      end
      run_idle(70, 400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pkfb_push_arbiter.md
PKFB_PUSH_ARBITER -- requirements
Module: pkfb_push_arbiter

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256: maximum words per packet; range 2..1024.
REQ-002 SHALL have port Sys_PKfb_Clk, input, 1 bit: sole clock; all state on the rising edge.
REQ-003 SHALL have port Sys_PKfb_Rst_n, input, 1 bit: reset, asynchronous assert, active-low; release synchronous to Sys_PKfb_Clk.
REQ-004 SHALL have port Req_Valid, input, 4 bits: requester i has a word pending.
REQ-005 SHALL have port Req_Data, input, 128 bits: word of requester i on bits [32i+31:32i].
REQ-006 SHALL have port Req_Last, input, 4 bits: the pending word of requester i ends its packet.
REQ-007 SHALL have port Req_Ready, output, 4 bits: the word of requester i is accepted this cycle when Req_Valid[i] is also high.
REQ-008 SHALL have port FB_PKfbData, output, 32 bits: packet word to the ASSP packet FIFO.
REQ-009 SHALL have port FB_PKfbPush, output, 4 bits: one-hot push strobe; bit i means channel i.
REQ-010 SHALL have port FB_PKfbSOF, output, 1 bit: the pushed word is the first word of its packet.
REQ-011 SHALL have port FB_PKfbEOF, output, 1 bit: the pushed word is the last word of its packet.
REQ-012 SHALL have port FB_PKfbOverflow, input, 1 bit: the ASSP FIFO rejected a push.
REQ-013 SHALL have port Sts_Clr, input, 1 bit: synchronous clear of all sticky status bits.
REQ-014 SHALL have port Ovf_Sticky, output, 4 bits: an overflow occurred during a packet of requester i.
REQ-015 SHALL have port Len_Err, output, 4 bits: a packet of requester i exceeded MAX_WORDS.
REQ-016 SHALL have port Grant, output, 4 bits: one-hot current owner; zero in IDLE.

Function
REQ-017 SHALL implement the states IDLE, XFER and DRAIN.
REQ-018 In IDLE with any Req_Valid high, SHALL select a requester round-robin, starting at the bit after the last owner (bit 0 after reset). SHALL register that requester into Grant and enter XFER on the next edge.
REQ-019 In IDLE, Req_Ready SHALL be 0. This gives at least one idle cycle between packets.
REQ-020 In XFER, Req_Ready SHALL equal Grant; all non-granted bits SHALL be 0.
REQ-021 Each accepted word SHALL appear on FB_PKfbData exactly one cycle after acceptance, with FB_PKfbPush = Grant. Outputs SHALL be registered.
REQ-022 FB_PKfbPush, SOF and EOF SHALL be 0 in every cycle without a push. FB_PKfbData SHALL hold its last value.
REQ-023 SOF SHALL be 1 only on the first pushed word of a packet. EOF SHALL be 1 on the word accepted with Req_Last. A one-word packet SHALL carry SOF and EOF together.
REQ-024 A word counter SHALL count accepted words per packet, reset to 0 on entry to XFER. It SHALL be wide enough for MAX_WORDS.
REQ-025 If word MAX_WORDS is accepted without Req_Last:
- that word SHALL be pushed with EOF forced to 1;
- Len_Err[owner] SHALL be set;
- the next state SHALL be DRAIN.
REQ-026 If FB_PKfbOverflow is sampled high in XFER:
- Ovf_Sticky[owner] SHALL be set;
- no further words SHALL be pushed for that packet;
- the next state SHALL be DRAIN, unless the word accepted in the same cycle has Req_Last, in which case the next state SHALL be IDLE.
REQ-027 In DRAIN, Req_Ready SHALL equal Grant, accepted words SHALL be discarded, and FB_PKfbPush SHALL stay 0. The word accepted with Req_Last SHALL return the block to IDLE.
REQ-028 On any return to IDLE, Grant SHALL clear and the round-robin pointer SHALL record the owner.
REQ-029 Requesters withdrawing Req_Valid mid-packet SHALL stall XFER or DRAIN without timeout. The word counter SHALL not advance during the stall.
REQ-030 Sts_Clr and a set event in the same cycle SHALL leave the bit set.
REQ-031 FB_PKfbOverflow sampled in IDLE SHALL be ignored.

Reset
REQ-032 While Sys_PKfb_Rst_n is low, the following SHALL be 0: all outputs, Grant, the state (IDLE), the word counter, the round-robin pointer (bit 0 next) and all sticky bits.
REQ-033 Reset asserted mid-packet SHALL abort immediately: no EOF SHALL be emitted for the aborted packet, and after release the block SHALL start in IDLE.

Verification
REQ-034 The bench SHALL cover: req0 sends 3 words (0xA0..0xA2, Last on the third) -> Push=0001 for 3 consecutive cycles, one cycle after each acceptance; SOF on 0xA0; EOF on 0xA2.
REQ-035 The bench SHALL cover: Req_Valid=1111 held, each requester sending one-word packets -> grants in the order 0,1,2,3,0; each push carries SOF=EOF=1; one idle cycle between grants.
REQ-036 The bench SHALL cover: MAX_WORDS=4 and req2 sends 6 words -> 4 pushes with EOF on the fourth; Len_Err=0100; words 5-6 are accepted but not pushed; return to IDLE.
REQ-037 The bench SHALL cover: Overflow pulsed after the second push of a 5-word packet from req1 -> Ovf_Sticky=0010; no further pushes; remaining words drained; IDLE after Last.
REQ-038 The bench SHALL cover: reset asserted during the third word of a packet -> all outputs 0 asynchronously; after release, req3 pending -> Grant=1000 two cycles later with a fresh SOF.
REQ-039 The bench SHALL cover: Sts_Clr pulsed in the same cycle as a new overflow on req0 -> Ovf_Sticky[0]=1; a later Sts_Clr alone clears it to 0.
